iram_fetch_arbiter: RTL and testbench

- Round-robin arbiter that shares the single-port IRAM among the N matrix-multiply cores; it sits between the cores' o_iram_* ports and the IRAM macro.
- Accepts at most one read/write request per cycle and forwards it as registered IRAM address/data/rden/wren.
- Returns read data on a broadcast bus, tagged with a one-hot per-core valid, RD_LAT cycles after the IRAM is driven.

---
 rtl/iram_fetch_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_iram_fetch_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// iram_fetch_arbiter
//
// Shares the single-port IRAM among N_CORES matrix-multiply cores. At most one
// request per cycle is accepted. The winner is picked round-robin, starting at
// a rotating priority pointer. The accepted access drives the IRAM through
// registered address, data, rden and wren outputs. Read data comes back on a
// broadcast bus. A one-hot o_rvalid tags it with the requesting core RD_LAT
// cycles after rden was driven.
//
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_req/i_we           per-core request and write qualifier
//   i_addr/i_wdata       flattened per-core address / write data
//   o_ack                one-hot, one-cycle accept pulse
//   o_iram_addr/_data    registered IRAM address / write data
//   o_iram_rden/_wren    registered IRAM read / write enable
//   i_iram_q             IRAM read data
//   o_rdata/o_rvalid     broadcast read data and its one-hot owner
//   o_busy               an accepted read is still in flight
//   o_grant_cnt          (only with IRAM_ARB_PERF_EN) per-core 16-bit
//                        saturating accept counters, flattened
//
// Optional feature macro: IRAM_ARB_PERF_EN
// -----------------------------------------------------------------------------
module iram_fetch_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_CORES-1:0]          i_req,
  input  logic [N_CORES-1:0]          i_we,
  input  logic [N_CORES*ADDR_W-1:0]   i_addr,
  input  logic [N_CORES*DATA_W-1:0]   i_wdata,
  output logic [N_CORES-1:0]          o_ack,
  output logic [ADDR_W-1:0]           o_iram_addr,
  output logic [DATA_W-1:0]           o_iram_data,
  output logic                        o_iram_rden,
  output logic                        o_iram_wren,
  input  logic [DATA_W-1:0]           i_iram_q,
  output logic [DATA_W-1:0]           o_rdata,
  output logic [N_CORES-1:0]          o_rvalid,
  output logic                        o_busy
`ifdef IRAM_ARB_PERF_EN
  ,
  output logic [N_CORES*16-1:0]       o_grant_cnt
`endif
);

  localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  // The candidate index is one bit wider so that ptr+offset cannot overflow
  // before the modulo wrap.
  localparam logic [PTR_W:0]   N_EXT    = (PTR_W+1)'(N_CORES);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_CORES-1);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [N_CORES-1:0] ack_q, ack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rden_q, rden_d;
  logic              wren_q, wren_d;

  // The read-return pipeline runs one stage behind rden. Each stage carries a
  // valid bit and the one-hot owner of that read.
  logic [RD_LAT-1:0]              pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0][N_CORES-1:0] pipe_id_q, pipe_id_d;

  logic [N_CORES-1:0] eligible;
  logic [PTR_W:0]     cand;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;

  logic [ADDR_W-1:0] addr_arr  [N_CORES];
  logic [DATA_W-1:0] wdata_arr [N_CORES];

  for (genvar gi = 0; gi < N_CORES; gi++) begin : g_unpack
    assign addr_arr[gi]  = i_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = i_wdata[gi*DATA_W +: DATA_W];
  end

  // Round-robin search. A core that is acked this cycle is masked, so a
  // request that is still high from last cycle's grant is not served twice.
  always_comb begin
    eligible  = i_req & ~ack_q;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < N_CORES; off++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(off);
      if (cand >= N_EXT) begin
        cand = cand - N_EXT;
      end
      if (!win_found && eligible[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    ack_d  = '0;
    addr_d = addr_q;
    data_d = data_q;
    rden_d = 1'b0;
    wren_d = 1'b0;
    ptr_d  = ptr_q;
    if (win_found) begin
      ack_d[win_idx] = 1'b1;
      addr_d         = addr_arr[win_idx];
      data_d         = wdata_arr[win_idx];
      rden_d         = ~i_we[win_idx];
      wren_d         = i_we[win_idx];
      ptr_d          = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
    end
  end

  // ack_q is the one-hot owner of the access that is currently on the IRAM
  // pins. Latch it only for reads, so that writes never reach o_rvalid.
  always_comb begin
    pipe_vld_d    = '0;
    pipe_id_d     = '0;
    pipe_vld_d[0] = rden_q;
    pipe_id_d[0]  = rden_q ? ack_q : '0;
    for (int k = 1; k < RD_LAT; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_id_d[k]  = pipe_id_q[k-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q      <= '0;
      ack_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rden_q     <= 1'b0;
      wren_q     <= 1'b0;
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      ack_q      <= ack_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rden_q     <= rden_d;
      wren_q     <= wren_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_id_q  <= pipe_id_d;
    end
  end

  assign o_ack       = ack_q;
  assign o_iram_addr = addr_q;
  assign o_iram_data = data_q;
  assign o_iram_rden = rden_q;
  assign o_iram_wren = wren_q;
  assign o_rdata     = i_iram_q;
  assign o_rvalid    = pipe_vld_q[RD_LAT-1] ? pipe_id_q[RD_LAT-1] : '0;
  assign o_busy      = (|pipe_vld_q) | rden_q;

`ifdef IRAM_ARB_PERF_EN
  // Each counter increments when its core is accepted and saturates at all-ones.
  for (genvar gi = 0; gi < N_CORES; gi++) begin : g_perf
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (ack_d[gi] && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign o_grant_cnt[gi*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_iram_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for iram_fetch_arbiter (N_CORES=4, ADDR_W=8, DATA_W=8, RD_LAT=1).
// A reference model samples the requests at every rising edge and picks the
// winner by round-robin. It then queues the expected accept and the expected
// read return, using its own copy of the IRAM contents. A monitor running on
// the falling edge pops those queues and compares them with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_iram_fetch_arbiter;

  localparam int N      = 4;
  localparam int RD_LAT = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    we  = '0;
  logic [7:0]      addr_v  [N];
  logic [7:0]      wdata_v [N];
  logic [N*8-1:0]  addr_f, wdata_f;
  logic [N-1:0]    o_ack, o_rvalid;
  logic [7:0]      o_iram_addr, o_iram_data, o_rdata;
  logic            o_iram_rden, o_iram_wren, o_busy;
  logic [7:0]      iram_q = '0;
  logic [7:0]      mem     [256];
  logic [7:0]      ref_mem [256];
`ifdef IRAM_ARB_PERF_EN
  logic [N*16-1:0] o_grant_cnt;
  int              m_cnt [N];
`endif

  typedef struct {
    int         cyc;
    int         core;
    logic [7:0] addr;
    logic [7:0] data;
    logic       we;
  } acc_t;

  acc_t ack_exp[$];
  acc_t rv_exp[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int m_ptr    = 0;
  int m_prev   = -1;

  always #5 clk = ~clk;

  always_comb begin
    addr_f  = '0;
    wdata_f = '0;
    for (int k = 0; k < N; k++) begin
      addr_f[k*8 +: 8]  = addr_v[k];
      wdata_f[k*8 +: 8] = wdata_v[k];
    end
  end

  iram_fetch_arbiter #(.N_CORES(N), .ADDR_W(8), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_we        (we),
    .i_addr      (addr_f),
    .i_wdata     (wdata_f),
    .o_ack       (o_ack),
    .o_iram_addr (o_iram_addr),
    .o_iram_data (o_iram_data),
    .o_iram_rden (o_iram_rden),
    .o_iram_wren (o_iram_wren),
    .i_iram_q    (iram_q),
    .o_rdata     (o_rdata),
    .o_rvalid    (o_rvalid),
    .o_busy      (o_busy)
`ifdef IRAM_ARB_PERF_EN
    ,
    .o_grant_cnt (o_grant_cnt)
`endif
  );

  // IRAM macro with a read latency of one cycle.
  always @(posedge clk) begin
    if (o_iram_wren) mem[o_iram_addr] <= o_iram_data;
    if (o_iram_rden) iram_q <= mem[o_iram_addr];
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model. The round-robin rule is applied to the sampled requests
  // and the result is scheduled as expected events.
  always @(posedge clk) begin
    if (rst) begin
      m_ptr  = 0;
      m_prev = -1;
      ack_exp.delete();
      rv_exp.delete();
`ifdef IRAM_ARB_PERF_EN
      foreach (m_cnt[k]) m_cnt[k] = 0;
`endif
    end else begin
      int   w;
      acc_t e;
      w = -1;
      for (int off = 0; off < N; off++) begin
        int idx;
        idx = (m_ptr + off) % N;
        if (w < 0 && req[idx] && idx != m_prev) w = idx;
      end
      m_prev = w;
      if (w >= 0) begin
        e.cyc  = cyc + 1;
        e.core = w;
        e.addr = addr_v[w];
        e.data = wdata_v[w];
        e.we   = we[w];
        ack_exp.push_back(e);
        if (we[w]) begin
          ref_mem[addr_v[w]] = wdata_v[w];
        end else begin
          e.cyc  = cyc + 1 + RD_LAT;
          e.data = ref_mem[addr_v[w]];
          rv_exp.push_back(e);
        end
        m_ptr = (w + 1) % N;
`ifdef IRAM_ARB_PERF_EN
        if (m_cnt[w] < 65535) m_cnt[w]++;
`endif
      end
    end
    cyc = cyc + 1;
  end

  // Monitor: on the falling edge, compare the DUT outputs with the scheduled
  // expectations.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_busy;
      acc_t e;
      exp_busy = 1'b0;
      foreach (rv_exp[i]) begin
        if (cyc >= rv_exp[i].cyc - RD_LAT && cyc <= rv_exp[i].cyc) exp_busy = 1'b1;
      end
      chk("busy", 32'(o_busy), 32'(exp_busy));

      if (ack_exp.size() > 0 && ack_exp[0].cyc == cyc) begin
        e = ack_exp.pop_front();
        $display("acc  cyc=%0d core=%0d we=%0b addr=%02h data=%02h", cyc, e.core, e.we, e.addr, e.data);
        chk("ack", 32'(o_ack), 32'(1) << e.core);
        chk("iram_addr", 32'(o_iram_addr), 32'(e.addr));
        chk("iram_rden", 32'(o_iram_rden), 32'(!e.we));
        chk("iram_wren", 32'(o_iram_wren), 32'(e.we));
        if (e.we) chk("iram_data", 32'(o_iram_data), 32'(e.data));
      end else begin
        chk("idle_ack_en", 32'({o_ack, o_iram_rden, o_iram_wren}), 32'(0));
      end

      if (rv_exp.size() > 0 && rv_exp[0].cyc == cyc) begin
        e = rv_exp.pop_front();
        $display("rd   cyc=%0d core=%0d addr=%02h rdata=%02h", cyc, e.core, e.addr, o_rdata);
        chk("rvalid", 32'(o_rvalid), 32'(1) << e.core);
        chk("rdata", 32'(o_rdata), 32'(e.data));
      end else begin
        chk("idle_rvalid", 32'(o_rvalid), 32'(0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int k, logic w, logic [7:0] a, logic [7:0] d);
    req[k]     = 1'b1;
    we[k]      = w;
    addr_v[k]  = a;
    wdata_v[k] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    we  = '0;
    ack_exp.delete();
    rv_exp.delete();
    #1;
    chk("rst_ack", 32'(o_ack), 32'(0));
    chk("rst_addr", 32'(o_iram_addr), 32'(0));
    chk("rst_data", 32'(o_iram_data), 32'(0));
    chk("rst_rden_wren", 32'({o_iram_rden, o_iram_wren}), 32'(0));
    chk("rst_rvalid", 32'(o_rvalid), 32'(0));
    chk("rst_busy", 32'(o_busy), 32'(0));
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int acks;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h3C]     = 8'hA5;
    ref_mem[8'h3C] = 8'hA5;
    for (int k = 0; k < N; k++) begin
      addr_v[k]  = '0;
      wdata_v[k] = '0;
    end

    step();
    do_reset();
    step();

    // Single read by core2.
    set_req(2, 1'b0, 8'h3C, 8'h00);
    step();
    chk("single_ack", 32'(o_ack), 32'h4);
    chk("single_addr", 32'(o_iram_addr), 32'h3C);
    chk("single_rden", 32'(o_iram_rden), 32'h1);
    req[2] = 1'b0;
    step();
    chk("single_rvalid", 32'(o_rvalid), 32'h4);
    chk("single_rdata", 32'(o_rdata), 32'hA5);

    // Write by core3.
    set_req(3, 1'b1, 8'h10, 8'h77);
    step();
    chk("write_wren", 32'({o_iram_wren, o_iram_rden}), 32'h2);
    chk("write_data", 32'(o_iram_data), 32'h77);
    req[3] = 1'b0;
    step();
    chk("write_no_rvalid", 32'(o_rvalid), 32'h0);

    // Four-way contention; the pointer is back at 0 after core3's grant.
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 8'(k + 8'h10), 8'h00);
    step();
    for (int i = 0; i < N; i++) begin
      chk("contend_order", 32'(o_ack), 32'(1) << i);
      req[i] = 1'b0;
      step();
    end
    step();

    // Core0 holds its request for 8 cycles and gets every other cycle.
    set_req(0, 1'b0, 8'h05, 8'h00);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_ack[0]) acks++;
    end
    chk("cont_ack_count", 32'(acks), 32'd4);
    // The pointer must now be at 1, so core1 wins over core0.
    set_req(1, 1'b0, 8'h06, 8'h00);
    step();
    chk("ptr_after_cont", 32'(o_ack), 32'h2);
    req[1] = 1'b0;
    step();
    chk("core0_after_core1", 32'(o_ack), 32'h1);
    req[0] = 1'b0;
    step();
    step();

    // Reset during an in-flight read by core1.
    set_req(1, 1'b0, 8'h3C, 8'h00);
    step();
    chk("midrst_busy_before", 32'(o_busy), 32'h1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("midrst_no_rvalid", 32'(o_rvalid), 32'h0);
      step();
    end

    // Random traffic: requests are held until acked, with occasional abandons.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (req[k] && o_ack[k]) begin
          req[k] = 1'b0;
        end else if (req[k] && $urandom_range(0, 15) == 0) begin
          req[k] = 1'b0;
        end else if (!req[k] && $urandom_range(0, 2) == 0) begin
          set_req(k, 1'($urandom_range(0, 2) == 0), 8'($urandom_range(0, 15)), 8'($urandom));
        end
      end
      step();
    end

    req = '0;
    repeat (RD_LAT + 4) step();
    chk("drain_ack_queue", 32'(ack_exp.size()), 32'd0);
    chk("drain_rv_queue", 32'(rv_exp.size()), 32'd0);
`ifdef IRAM_ARB_PERF_EN
    for (int k = 0; k < N; k++) chk("grant_cnt", 32'(o_grant_cnt[k*16 +: 16]), 32'(m_cnt[k]));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
